// File: rtl/inpass4_sync_filter.sv
// ---------------------------------------------------------------------------
// inpass4_sync_filter
//
// Purpose:
//    Brings four asynchronous pad inputs into the UserCLK domain through a
//    two-flop synchronizer per bit. Each bit can optionally be debounced: a
//    new level is only accepted once the synchronized value has disagreed
//    with the current output for more than N consecutive cycles. The result
//    feeds the downstream input-pass BEL's I pins straight from flops.
//
// Ports:
//    UserCLK    - single rising-edge clock shared with the other BELs
//    resetn     - asynchronous, active-low reset (clears every flop)
//    I[3:0]     - external pad inputs, asynchronous to UserCLK
//    ConfigBits - [3:0] per-bit filter enable, [7:4] shared threshold N
//    O[3:0]     - synchronized, filtered outputs (registered)
//    Rise[3:0]  - one-cycle pulse when O[b] goes 0->1 (optional)
//    Fall[3:0]  - one-cycle pulse when O[b] goes 1->0 (optional)
//
// Parameters:
//    NoConfigBits - width of the configuration word (default 8)
//    FILTER_W     - width of each debounce counter (default 4)
//
// Build option:
//    Define INPASS4_SYNC_FILTER_EDGE_EN to add the Rise/Fall edge outputs
//    and their flops. Without it, only O is produced.
// ---------------------------------------------------------------------------
module inpass4_sync_filter #(
   parameter int NoConfigBits = 8,
   parameter int FILTER_W     = 4
) (
   input  logic                    UserCLK,
   input  logic                    resetn,
   input  logic [3:0]              I,
   input  logic [NoConfigBits-1:0] ConfigBits,
   output logic [3:0]              O
`ifdef INPASS4_SYNC_FILTER_EDGE_EN
   ,
   output logic [3:0]              Rise,
   output logic [3:0]              Fall
`endif
);

   logic [3:0]          sync1;
   logic [3:0]          sync2;
   logic [3:0]          qReg;
   logic [3:0]          qNext;
   logic [FILTER_W-1:0] cnt     [4];
   logic [FILTER_W-1:0] cntNext [4];
   logic [FILTER_W-1:0] threshold;
   logic [3:0]          filterEn;

   assign filterEn  = ConfigBits[3:0];
   assign threshold = FILTER_W'(ConfigBits[7:4]);

   // The output comes straight off the q flops so there is never a
   // combinational path from the pads to the downstream BEL.
   assign O = qReg;

   // Next-state for each bit's output flop and debounce counter. Bits are
   // handled independently. The counter defaults to zero so that it clears
   // whenever the synchronized value agrees with the output, whenever the
   // filter is disabled, and whenever a change is accepted. The >= test
   // (rather than ==) means that lowering N below the current count lets
   // the pending change through on the very next edge instead of waiting
   // for a counter wrap.
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         qNext[b]   = qReg[b];
         cntNext[b] = '0;
         if (!filterEn[b]) begin
            qNext[b] = sync2[b];
         end else if (sync2[b] != qReg[b]) begin
            if (cnt[b] >= threshold) begin
               qNext[b] = sync2[b];
            end else begin
               cntNext[b] = cnt[b] + FILTER_W'(1);
            end
         end
      end
   end

   // Synchronizer chain, output flops and counters. Reset clears them all
   // asynchronously, which also throws away any change that was still
   // being debounced; the first update after release happens on the next
   // rising edge.
   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         sync1 <= '0;
         sync2 <= '0;
         qReg  <= '0;
         for (int b = 0; b < 4; b++) begin
            cnt[b] <= '0;
         end
      end else begin
         sync1 <= I;
         sync2 <= sync1;
         qReg  <= qNext;
         for (int b = 0; b < 4; b++) begin
            cnt[b] <= cntNext[b];
         end
      end
   end

`ifdef INPASS4_SYNC_FILTER_EDGE_EN
   // Edge pulses are registered from the same next-state as the q flops,
   // so each pulse appears on the same edge as the O change it reports
   // and lasts exactly one cycle.
   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         Rise <= '0;
         Fall <= '0;
      end else begin
         Rise <= qNext & ~qReg;
         Fall <= ~qNext & qReg;
      end
   end
`endif

endmodule

// File: tb/tb_inpass4_sync_filter.sv
// ---------------------------------------------------------------------------
// tb_inpass4_sync_filter
//
// Directed testbench for inpass4_sync_filter. Expected outputs are worked
// out from the documented latencies (2 edges unfiltered, 2+N edges when
// filtered) and queued against the cycle on which they must appear; a
// checker pops and compares them on the falling clock edge.
// Define INPASS4_SYNC_FILTER_EDGE_EN to also exercise Rise/Fall.
// ---------------------------------------------------------------------------
module tb_inpass4_sync_filter;

   typedef struct {
      int         cycle;
      logic [3:0] expO;
      logic       chkEdge;
      logic [3:0] expRise;
      logic [3:0] expFall;
      string      tag;
   } ScoreEntry_t;

   logic       UserCLK;
   logic       resetn;
   logic [3:0] I;
   logic [7:0] ConfigBits;
   logic [3:0] O;
`ifdef INPASS4_SYNC_FILTER_EDGE_EN
   logic [3:0] Rise;
   logic [3:0] Fall;
`endif

   int          cyc = 0;
   int          testCount = 0;
   int          failCount = 0;
   ScoreEntry_t sbQueue[$];
   ScoreEntry_t entry;

   inpass4_sync_filter #(
      .NoConfigBits(8),
      .FILTER_W(4)
   ) dut (
      .UserCLK(UserCLK),
      .resetn(resetn),
      .I(I),
      .ConfigBits(ConfigBits),
      .O(O)
`ifdef INPASS4_SYNC_FILTER_EDGE_EN
      ,
      .Rise(Rise),
      .Fall(Fall)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      UserCLK = 1'b0;
      forever #5 UserCLK = ~UserCLK;
   end

   // Count rising edges; at each falling edge cyc equals the number of
   // rising edges seen so far.
   always @(posedge UserCLK) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [3:0] observed,
                              input logic [3:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)",
                tag, observed, expected, cyc);
      end
   endtask

   // Scoreboard checker: compare every queued expectation whose cycle has
   // arrived. An entry whose cycle already passed counts as a failure.
   always @(negedge UserCLK) begin
      while (sbQueue.size() > 0 && sbQueue[0].cycle <= cyc) begin
         entry = sbQueue.pop_front();
         testCount++;
         assert (entry.cycle === cyc)
         else begin
            failCount++;
            $error("[TB] FAIL %s: checked at cycle %0d expected cycle %0d",
                   entry.tag, cyc, entry.cycle);
         end
         checkOutput(entry.tag, O, entry.expO);
`ifdef INPASS4_SYNC_FILTER_EDGE_EN
         if (entry.chkEdge) begin
            checkOutput({entry.tag, "_rise"}, Rise, entry.expRise);
            checkOutput({entry.tag, "_fall"}, Fall, entry.expFall);
         end
`endif
      end
   end

   task automatic applyStimulus(input logic [3:0] iVal, input logic [7:0] cfg);
      I          = iVal;
      ConfigBits = cfg;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge UserCLK);
      #1;
   endtask

   task automatic expectAt(input int delta, input logic [3:0] o, input string tag);
      ScoreEntry_t e;
      e.cycle   = cyc + delta;
      e.expO    = o;
      e.chkEdge = 1'b0;
      e.expRise = '0;
      e.expFall = '0;
      e.tag     = tag;
      sbQueue.push_back(e);
   endtask

   task automatic expectEdgeAt(input int delta, input logic [3:0] o,
                               input logic [3:0] r, input logic [3:0] f,
                               input string tag);
      ScoreEntry_t e;
      e.cycle   = cyc + delta;
      e.expO    = o;
      e.chkEdge = 1'b1;
      e.expRise = r;
      e.expFall = f;
      e.tag     = tag;
      sbQueue.push_back(e);
   endtask

   // Directed sequence. Inputs change 1 time unit after a falling edge, so
   // the next rising edge is E0 and a change is due on O at cyc+3 when
   // unfiltered or cyc+3+N when filtered.
   initial begin
      resetn = 1'b0;
      applyStimulus(4'h0, 8'h00);
      waitCycles(1);

      // Reset holds O at zero even with all pads high.
      applyStimulus(4'hF, 8'h00);
      expectAt(1, 4'h0, "reset_hold1");
      expectAt(2, 4'h0, "reset_hold2");
      expectAt(3, 4'h0, "reset_hold3");
      waitCycles(3);
      applyStimulus(4'h0, 8'h00);
      resetn = 1'b1;
      expectAt(2, 4'h0, "post_release");
      waitCycles(3);

      // Unfiltered: only bit 0 moves, two edges after sampling.
      applyStimulus(4'h1, 8'h00);
      expectAt(2, 4'h0, "unf_rise_early");
      expectAt(3, 4'h1, "unf_rise");
      waitCycles(4);
      applyStimulus(4'h0, 8'h00);
      expectAt(2, 4'h1, "unf_fall_early");
      expectAt(3, 4'h0, "unf_fall");
      waitCycles(4);

      // Debounce N=3 on bit 0, level held.
      applyStimulus(4'h1, 8'h31);
      expectAt(5, 4'h0, "deb_rise_early");
      expectAt(6, 4'h1, "deb_rise");
      waitCycles(8);
      applyStimulus(4'h0, 8'h31);
      expectAt(5, 4'h1, "deb_fall_early");
      expectAt(6, 4'h0, "deb_fall");
      waitCycles(8);

      // A 3-cycle pulse is rejected.
      applyStimulus(4'h1, 8'h31);
      for (int d = 1; d <= 8; d++) expectAt(d, 4'h0, "pulse3_reject");
      waitCycles(3);
      applyStimulus(4'h0, 8'h31);
      waitCycles(6);

      // Counter was cleared: a held level again needs the full N cycles.
      applyStimulus(4'h1, 8'h31);
      expectAt(3, 4'h0, "cnt_clear_e3");
      expectAt(4, 4'h0, "cnt_clear_e4");
      expectAt(5, 4'h0, "cnt_clear_e5");
      expectAt(6, 4'h1, "cnt_clear_rise");
      waitCycles(7);
      applyStimulus(4'h0, 8'h31);
      expectAt(5, 4'h1, "cnt_clear_fall_early");
      expectAt(6, 4'h0, "cnt_clear_fall");
      waitCycles(7);

      // A 4-cycle pulse (N+1) is just long enough to pass.
      applyStimulus(4'h1, 8'h31);
      expectAt(5, 4'h0, "pulse4_early");
      expectAt(6, 4'h1, "pulse4_rise");
      expectAt(9, 4'h1, "pulse4_hold");
      expectAt(10, 4'h0, "pulse4_fall");
      waitCycles(4);
      applyStimulus(4'h0, 8'h31);
      waitCycles(7);

      // Independent bits: bit 1 unfiltered, bit 0 filtered with N=3.
      applyStimulus(4'h3, 8'h31);
      expectAt(2, 4'h0, "indep_rise_e2");
      expectAt(3, 4'h2, "indep_rise_bit1");
      expectAt(5, 4'h2, "indep_rise_e5");
      expectAt(6, 4'h3, "indep_rise_bit0");
      waitCycles(8);
      applyStimulus(4'h0, 8'h31);
      expectAt(2, 4'h3, "indep_fall_e2");
      expectAt(3, 4'h1, "indep_fall_bit1");
      expectAt(5, 4'h1, "indep_fall_e5");
      expectAt(6, 4'h0, "indep_fall_bit0");
      waitCycles(8);

      // N=0 with every bit filtered behaves like unfiltered.
      applyStimulus(4'hF, 8'h0F);
      expectAt(2, 4'h0, "n0_rise_early");
      expectAt(3, 4'hF, "n0_rise");
      waitCycles(4);
      applyStimulus(4'h0, 8'h0F);
      expectAt(2, 4'hF, "n0_fall_early");
      expectAt(3, 4'h0, "n0_fall");
      waitCycles(4);

`ifdef INPASS4_SYNC_FILTER_EDGE_EN
      // Edge pulses coincide with the O change and last one cycle.
      applyStimulus(4'hA, 8'h00);
      expectEdgeAt(2, 4'h0, 4'h0, 4'h0, "edge_pre");
      expectEdgeAt(3, 4'hA, 4'hA, 4'h0, "edge_rise");
      expectEdgeAt(4, 4'hA, 4'h0, 4'h0, "edge_rise_end");
      waitCycles(5);
      applyStimulus(4'h0, 8'h00);
      expectEdgeAt(2, 4'hA, 4'h0, 4'h0, "edge_pre_fall");
      expectEdgeAt(3, 4'h0, 4'h0, 4'hA, "edge_fall");
      expectEdgeAt(4, 4'h0, 4'h0, 4'h0, "edge_fall_end");
      waitCycles(5);
`endif

      // Threshold drop: N=15, count reaches 9, then N becomes 4.
      applyStimulus(4'h1, 8'hF1);
      expectAt(11, 4'h0, "thr_cnt9");
      waitCycles(11);
      applyStimulus(4'h1, 8'h41);
      expectAt(1, 4'h1, "thr_drop");
      waitCycles(2);
      applyStimulus(4'h0, 8'h41);
      expectAt(6, 4'h1, "thr_n4_fall_early");
      expectAt(7, 4'h0, "thr_n4_fall");
      waitCycles(9);

      // Disabling the filter mid-count passes the level on the next edge.
      applyStimulus(4'h1, 8'hF1);
      expectAt(3, 4'h0, "dis_counting");
      waitCycles(3);
      applyStimulus(4'h1, 8'hF0);
      expectAt(1, 4'h1, "dis_pass");
      waitCycles(2);
      applyStimulus(4'h0, 8'hF0);
      expectAt(2, 4'h1, "dis_fall_early");
      expectAt(3, 4'h0, "dis_fall");
      waitCycles(4);

      // Reset mid-count with N=7 on all bits.
      applyStimulus(4'hF, 8'h7F);
      expectAt(7, 4'h0, "rst_mid_cnt5");
      waitCycles(7);
      resetn = 1'b0;
      #1;
      checkOutput("rst_mid_immediate", O, 4'h0);
      expectAt(1, 4'h0, "rst_mid_held1");
      expectAt(2, 4'h0, "rst_mid_held2");
      waitCycles(2);
      resetn = 1'b1;
      expectAt(3, 4'h0, "rst_restart_e3");
      expectAt(9, 4'h0, "rst_restart_e9");
      expectAt(10, 4'hF, "rst_restart_rise");
      waitCycles(11);
      applyStimulus(4'h0, 8'h7F);
      expectAt(9, 4'hF, "rst_fall_early");
      expectAt(10, 4'h0, "rst_fall");
      waitCycles(11);

      // Everything queued must have been checked.
      testCount++;
      assert (sbQueue.size() === 0)
      else begin
         failCount++;
         $error("[TB] FAIL sb_drain: observed %0d pending expected 0",
                sbQueue.size());
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/inpass4_sync_filter.md
INPASS4_SYNC_FILTER -- requirements
Module: inpass4_sync_filter

Interface
REQ-001 Parameter NoConfigBits, default 8, SHALL be the configuration-bit count.
REQ-002 Parameter FILTER_W, default 4, SHALL be the debounce counter width.
REQ-003 UserCLK  input  1  SHALL be the single clock, shared with the other BELs, sent to top, all flops rising-edge.
REQ-004 resetn  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 I  input  4  SHALL be the external pad inputs, sent to top, asynchronous to UserCLK.
REQ-006 O  output  4  SHALL be the synchronized, filtered values feeding the downstream input-pass BEL's I pins.
REQ-007 ConfigBits  input  NoConfigBits  SHALL be the global configuration word: [3:0] per-bit filter enable, [7:4] debounce threshold N (0..15, shared by all bits).

Function
REQ-008 Each bit b SHALL pass through a two-flop synchronizer s1[b] <= I[b], s2[b] <= s1[b].
REQ-009 O[b] SHALL be driven directly from flop q[b]; no combinational path from I to O.
REQ-010 Filter disabled (ConfigBits[b]=0): q[b] <= s2[b] each edge, with cnt[b] held at 0.
REQ-011 Filter enabled: if s2[b]==q[b], cnt[b] <= 0; else if cnt[b] >= N, then q[b] <= s2[b] and cnt[b] <= 0; else cnt[b] <= cnt[b]+1.
REQ-012 Latency: a level change on I[b], setup-valid before edge E0, SHALL appear on O[b] at edge E0+2 when unfiltered, or at E0+2+N when filtered and held stable.
REQ-013 With N=0, filtered behaviour SHALL be identical to unfiltered.
REQ-014 A disagreement on s2[b] lasting N or fewer consecutive cycles SHALL clear cnt[b] and leave O[b] unchanged.
REQ-015 cnt[b] SHALL never exceed N and never wrap; the >= comparison SHALL make a mid-count reduction of N take effect on the next edge.
REQ-016 Changing ConfigBits[b] from 1 to 0 SHALL clear cnt[b] on the next edge.
REQ-017 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each follow their own counter.

Reset
REQ-018 resetn low SHALL asynchronously clear s1, s2, q, cnt and (when compiled in) Rise/Fall, so O=4'b0000.
REQ-019 Reset asserted mid-count SHALL discard the pending change; after release, the filter SHALL restart from O=0 and cnt=0.
REQ-020 Reset release SHALL be synchronous in effect: the first update SHALL occur on the first UserCLK edge after resetn rises.

Configuration
REQ-021 Macro INPASS4_SYNC_FILTER_EDGE_EN, when defined, SHALL add outputs Rise[3:0] and Fall[3:0].
REQ-022 With the macro defined, Rise[b] SHALL pulse high for exactly one cycle on the edge where q[b] goes 0->1, coincident with O[b]; Fall[b] SHALL do likewise for 1->0.
REQ-023 Without the macro, Rise, Fall and their flops SHALL be absent, and O behaviour SHALL be unchanged.

Verification
REQ-024 Unfiltered: ConfigBits=8'h00, I[0] 0->1 before edge E0 -> O[0]=1 at E0+2; other bits stay 0.
REQ-025 Debounce: ConfigBits=8'h31 (N=3, bit0 filtered), I[0] held high -> O[0]=1 at E0+5; a 3-cycle pulse produces no O change and cnt returns to 0.
REQ-026 Threshold drop: N=15 with cnt[0]=9, ConfigBits[7:4] rewritten to 4 -> O[0] updates on the next edge.
REQ-027 Reset mid-count: N=7, assert resetn low at cnt=5 -> O=0 immediately; after release with I=4'hF, O=4'hF at 2+7 edges after the first sampling edge.
REQ-028 Edge pulses (macro defined): I toggles 4'h0->4'hA->4'h0 unfiltered -> Rise=4'hA for one cycle, then Fall=4'hA for one cycle, each coincident with the O change.
